// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, taken-branch flush
// and saturating stall/flush event counters.
module if_id_stage #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [31:0]      instr_i,
  input  logic             branch_taken_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rd_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [31:0]      instr_o,
  output logic             valid_o,
  output logic             hazard_o,
  output logic             pc_write_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [6:0] opc;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       rs1_used;
  logic       rs2_used;
  logic       rs1_hit;
  logic       rs2_hit;

  assign opc = instr_o[6:0];
  assign rs1 = instr_o[19:15];
  assign rs2 = instr_o[24:20];

  // Which source registers the held instruction actually reads.
  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opc)
      OPC_RTYPE, OPC_STORE, OPC_BRANCH: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPC_ITYPE, OPC_LOAD: rs1_used = 1'b1;
      default: ;
    endcase
  end

  assign rs1_hit = rs1_used && (rs1 == idex_rd_i);
  assign rs2_hit = rs2_used && (rs2 == idex_rd_i);

  // Bubbles never stall; a load into x0 never produces a usable value to wait for.
  assign hazard_o   = valid_o && idex_memread_i && (idex_rd_i != 5'd0) && (rs1_hit || rs2_hit);
  assign pc_write_o = !hazard_o;
  assign flush_o    = branch_taken_i && !hazard_o;

  // Pipeline register: stall holds, flush inserts a bubble, otherwise advance.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_o    <= '0;
      instr_o <= NOP_INSTR;
      valid_o <= 1'b0;
    end else if (hazard_o) begin
      pc_o    <= pc_o;
      instr_o <= instr_o;
      valid_o <= valid_o;
    end else if (flush_o) begin
      pc_o    <= pc_i;
      instr_o <= NOP_INSTR;
      valid_o <= 1'b0;
    end else begin
      pc_o    <= pc_i;
      instr_o <= instr_i;
      valid_o <= 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (hazard_o && (stall_cnt_o != CNT_MAX)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (flush_o && (flush_cnt_o != CNT_MAX)) begin
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: directed rows push expected state, a
// negedge monitor pops and compares against two instances (default and CNT_W=2).
module tb_if_id_stage;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] NOP2 = 32'h00208133;
  localparam logic [31:0] I_A  = 32'h00100093;
  localparam logic [31:0] I_B  = 32'h00200113;
  localparam logic [31:0] I_C  = 32'h00300193;
  localparam logic [31:0] I_ADD = 32'h00208133;
  localparam logic [31:0] I_ADDI5 = 32'h00308293;
  localparam logic [31:0] I_SW = 32'h0030a023;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        hz;
    logic        fl;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] instr_i = '0;
  logic        br = 1'b0;
  logic        mr = 1'b0;
  logic [4:0]  rd = '0;

  logic [31:0] pc_o, instr_o, pc2, instr2;
  logic        valid_o, hazard_o, pc_write_o, flush_o;
  logic        valid2, hazard2, pc_write2, flush2;
  logic [15:0] sc_o, fc_o;
  logic [1:0]  sc2, fc2;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   row_id = 0;

  always #5 clk = ~clk;

  if_id_stage #(.XLEN(32), .NOP_INSTR(NOP), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_n), .pc_i(pc_i), .instr_i(instr_i),
    .branch_taken_i(br), .idex_memread_i(mr), .idex_rd_i(rd),
    .pc_o(pc_o), .instr_o(instr_o), .valid_o(valid_o), .hazard_o(hazard_o),
    .pc_write_o(pc_write_o), .flush_o(flush_o),
    .stall_cnt_o(sc_o), .flush_cnt_o(fc_o)
  );

  // Second copy: narrow counters and a bubble whose fields look like add x2,x1,x2.
  if_id_stage #(.XLEN(32), .NOP_INSTR(NOP2), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst_n), .pc_i(pc_i), .instr_i(instr_i),
    .branch_taken_i(br), .idex_memread_i(mr), .idex_rd_i(rd),
    .pc_o(pc2), .instr_o(instr2), .valid_o(valid2), .hazard_o(hazard2),
    .pc_write_o(pc_write2), .flush_o(flush2),
    .stall_cnt_o(sc2), .flush_cnt_o(fc2)
  );

  task automatic chk(input int id, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row%0d %s: got %h expected %h", id, name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat3(input logic [15:0] v);
    return (v > 16'd3) ? 32'd3 : 32'(v);
  endfunction

  // Monitor: one expected entry per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.id, "pc",        pc_o,                 e.pc);
      chk(e.id, "instr",     instr_o,              e.instr);
      chk(e.id, "valid",     32'(valid_o),         32'(e.valid));
      chk(e.id, "hazard",    32'(hazard_o),        32'(e.hz));
      chk(e.id, "pc_write",  32'(pc_write_o),      32'(!e.hz));
      chk(e.id, "flush",     32'(flush_o),         32'(e.fl));
      chk(e.id, "stall_cnt", 32'(sc_o),            32'(e.sc));
      chk(e.id, "flush_cnt", 32'(fc_o),            32'(e.fc));
      chk(e.id, "hazard2",   32'(hazard2),         32'(e.hz));
      chk(e.id, "instr2",    instr2,               e.valid ? e.instr : NOP2);
      chk(e.id, "stall2",    32'(sc2),             sat3(e.sc));
      chk(e.id, "flush2",    32'(fc2),             sat3(e.fc));
    end
  end

  // Drive one cycle of inputs just after the edge and queue the expected view.
  task automatic row(input logic r, input logic [31:0] p, input logic [31:0] ins,
                     input logic b, input logic m, input logic [4:0] d,
                     input logic [31:0] e_pc, input logic [31:0] e_ins,
                     input logic e_v, input logic e_hz, input logic e_fl,
                     input int e_sc, input int e_fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; pc_i = p; instr_i = ins; br = b; mr = m; rd = d;
    e.id = row_id; e.pc = e_pc; e.instr = e_ins; e.valid = e_v; e.hz = e_hz;
    e.fl = e_fl; e.sc = 16'(e_sc); e.fc = 16'(e_fc);
    sb.push_back(e);
    row_id++;
  endtask

  initial begin
    //   rst pc     instr    br mr rd    pc     instr    v  hz fl sc fc
    row(0, 0,  I_A,     0, 0, 0,  0,  NOP,     0, 0, 0, 0, 0);
    row(0, 0,  I_A,     0, 0, 0,  0,  NOP,     0, 0, 0, 0, 0);
    row(1, 0,  I_A,     0, 0, 0,  0,  NOP,     0, 0, 0, 0, 0);
    row(1, 4,  I_B,     0, 0, 0,  0,  I_A,     1, 0, 0, 0, 0);
    row(1, 8,  I_C,     0, 0, 0,  4,  I_B,     1, 0, 0, 0, 0);
    row(1, 12, I_ADD,   0, 0, 0,  8,  I_C,     1, 0, 0, 0, 0);
    // load-use on rs1
    row(1, 16, I_A,     0, 1, 1,  12, I_ADD,   1, 1, 0, 0, 0);
    row(1, 16, I_A,     0, 0, 1,  12, I_ADD,   1, 0, 0, 1, 0);
    row(1, 20, I_ADDI5, 0, 0, 0,  16, I_A,     1, 0, 0, 1, 0);
    // I-type ignores rs2 field; store uses it
    row(1, 24, I_SW,    0, 1, 3,  20, I_ADDI5, 1, 0, 0, 1, 0);
    row(1, 28, I_A,     0, 1, 3,  24, I_SW,    1, 1, 0, 1, 0);
    // hazard beats branch
    row(1, 28, I_A,     1, 1, 3,  24, I_SW,    1, 1, 0, 2, 0);
    row(1, 28, I_A,     1, 0, 3,  24, I_SW,    1, 0, 1, 3, 0);
    // bubble never stalls (dut2 bubble has rs1=x1)
    row(1, 32, I_B,     0, 1, 1,  28, NOP,     0, 0, 0, 3, 1);
    // load to x0 never stalls
    row(1, 36, I_A,     0, 1, 0,  32, I_B,     1, 0, 0, 3, 1);
    row(1, 40, I_ADD,   0, 0, 0,  36, I_A,     1, 0, 0, 3, 1);
    // five-cycle hazard on rs2 of R-type; dut2 counter saturates at 3
    for (int i = 0; i < 5; i++)
      row(1, 44, I_B,   0, 1, 2,  40, I_ADD,   1, 1, 0, 3 + i, 1);
    row(1, 44, I_B,     0, 0, 2,  40, I_ADD,   1, 0, 0, 8, 1);
    row(1, 48, I_C,     0, 0, 0,  44, I_B,     1, 0, 0, 8, 1);
    // async reset mid-cycle, no clock edge in between
    row(0, 52, I_C,     0, 0, 0,  0,  NOP,     0, 0, 0, 0, 0);
    row(1, 0,  I_A,     0, 0, 0,  0,  NOP,     0, 0, 0, 0, 0);
    row(1, 4,  I_B,     0, 0, 0,  0,  I_A,     1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline register for the 5-stage core, with integrated load-use hazard detection and taken-branch flush.
- Captures the fetched PC and instruction, and presents them to the ID stage (decode, register file, main control).
- Drives the PC write-enable and the control-zeroing stall signal.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- XLEN, 32, width of PC.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) loaded on reset and flush.
- CNT_W, 16, width of stall/flush counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- pc_i  in  XLEN  PC of the instruction being fetched.
- instr_i  in  32  fetched instruction.
- branch_taken_i  in  1  ID-stage decision (Branch AND RegEqual) for the instruction currently in instr_o.
- idex_memread_i  in  1  ID/EX register holds a load.
- idex_rd_i  in  5  destination register held in ID/EX.
- pc_o  out  XLEN  registered PC to ID.
- instr_o  out  32  registered instruction to ID.
- valid_o  out  1  instr_o is a real instruction (0 = bubble).
- hazard_o  out  1  combinational load-use stall; the ID-side mux zeroes control signals into ID/EX.
- pc_write_o  out  1  combinational PC write enable, equal to !hazard_o.
- flush_o  out  1  combinational, equal to branch_taken_i && !hazard_o.
- stall_cnt_o  out  CNT_W  stall cycle count.
- flush_cnt_o  out  CNT_W  flush count.

Behaviour:
- Reset: while rst_i=0, asynchronously force pc_o=0, instr_o=NOP_INSTR, valid_o=0, stall_cnt_o=0, flush_cnt_o=0. Release is synchronous to the next edge.
- Field decode, taken from the registered instruction instr_o:
  - opc=[6:0], rs1=[19:15], rs2=[24:20].
  - rs1 is used by opcodes 0110011, 0010011, 0000011, 0100011, 1100011.
  - rs2 is used only by 0110011, 0100011, 1100011.
  - Any other opcode uses neither register.
- hazard_o = valid_o && idex_memread_i && idex_rd_i!=0 && ((rs1 used && rs1==idex_rd_i) || (rs2 used && rs2==idex_rd_i)).
  - This is purely combinational, with no cycle of latency.
- Each rising edge, in priority order:
  1. hazard_o=1 (stall): hold pc_o, instr_o and valid_o unchanged. branch_taken_i is ignored because the operands are not yet valid. stall_cnt_o increments.
  2. Else flush_o=1: load instr_o=NOP_INSTR, valid_o=0, and pc_o=pc_i (don't-care value, but defined). flush_cnt_o increments. The PC still writes the branch target.
  3. Else (normal): load pc_o=pc_i, instr_o=instr_i, valid_o=1.
- Stall length: a single load-use costs exactly one stall cycle. After the edge, ID/EX holds a bubble (memread=0), so hazard_o drops.
- Bubble behaviour: a bubble (valid_o=0) never raises hazard_o, even if its fields match.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Latency: pc_o/instr_o/valid_o have 1-cycle latency from pc_i/instr_i.
- Reset mid-stall or mid-flush: reset wins immediately and all state returns to reset values.
- rd=x0: a load to x0 never stalls.

Test Plan:
1. Reset then stream: assert rst_i=0 for 2 cycles, then release.
   - Required during reset: instr_o=32'h00000013, valid_o=0.
   - Then feed pc 0,4,8 with instrs A,B,C: instr_o follows one cycle later, valid_o=1, hazard_o=0, pc_write_o=1.
2. Load-use on rs1:
   - Setup: instr_o=32'h00208133 (add x2,x1,x2), idex_memread_i=1, idex_rd_i=1.
   - Required: hazard_o=1, pc_write_o=0.
   - Next edge: instr_o and pc_o unchanged, stall_cnt_o=1.
   - Then set idex_memread_i=0: hazard_o=0 and the pipeline advances.
3. rs2-usage rule:
   - Setup: instr_o=addi x5,x1,3 (32'h00308293), idex_memread_i=1, idex_rd_i=3 (matching the immediate bits in [24:20]).
   - Required: hazard_o=0.
   - Same rd against sw x3,0(x1) (32'h0030a023): hazard_o=1.
4. Branch flush and priority:
   - With no hazard, branch_taken_i=1: flush_o=1; next edge instr_o=NOP_INSTR, valid_o=0, flush_cnt_o=1.
   - With hazard and branch_taken_i=1 at the same time: flush_o=0, register held, flush_cnt_o unchanged.
5. x0 and bubble cases:
   - idex_rd_i=0 with a matching rs1=0: hazard_o=0.
   - valid_o=0 with matching fields: hazard_o=0.
6. Counter saturation and async reset:
   - With CNT_W=2, hold a hazard for 5 cycles: stall_cnt_o=3 (saturated).
   - Drop rst_i mid-cycle: outputs clear without waiting for a clock edge.
